// File: rtl/sram_ctrl.sv
// sram_ctrl: request/response controller for an asynchronous single-port SRAM.
// A request is latched on the req_valid/req_ready handshake. The controller
// then walks SETUP -> ACCESS -> HOLD, keeping chip select low for
// WAIT_CYCLES cycles. All SRAM pins are driven from registers.
// Optional feature: define SRAM_CTRL_WR_VERIFY_EN to read back every write
// (TURN -> VERIFY) and flag a data mismatch on wr_err_o.
module sram_ctrl #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic       req_rw_i,
    input  logic [5:0] req_row_i,
    input  logic [5:0] req_col_i,
    input  logic [7:0] req_wdata_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_rdata_o,
    output logic       wr_err_o,
    output logic       busy_o,
    output logic       sram_cs_o,
    output logic       sram_rw_o,
    output logic [5:0] sram_row_o,
    output logic [5:0] sram_col_o,
    output logic [7:0] sram_din_o,
    input  logic [7:0] sram_dout_i
);

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, TURN, VERIFY, HOLD} state_t;

    // Counter reload value; the counter runs down to zero across the cs-low window.
    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       rw_q, rw_d;
    logic       sram_cs_q, sram_cs_d;
    logic       sram_rw_q, sram_rw_d;
    logic [5:0] sram_row_q, sram_row_d;
    logic [5:0] sram_col_q, sram_col_d;
    logic [7:0] sram_din_q, sram_din_d;
    logic [7:0] rdata_q, rdata_d;
`ifdef SRAM_CTRL_WR_VERIFY_EN
    logic       err_q, err_d;
    logic [7:0] vdata_q, vdata_d;
`endif

    // Next-state and registered-pin logic; every register holds unless a state changes it.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rw_d       = rw_q;
        sram_cs_d  = sram_cs_q;
        sram_rw_d  = sram_rw_q;
        sram_row_d = sram_row_q;
        sram_col_d = sram_col_q;
        sram_din_d = sram_din_q;
        rdata_d    = rdata_q;
`ifdef SRAM_CTRL_WR_VERIFY_EN
        err_d      = err_q;
        vdata_d    = vdata_q;
`endif
        case (state_q)
            IDLE: begin
                // Pins are loaded while cs is still high, so they are settled
                // for the whole SETUP cycle before cs falls.
                if (req_valid_i) begin
                    state_d    = SETUP;
                    rw_d       = req_rw_i;
                    sram_rw_d  = req_rw_i;
                    sram_row_d = req_row_i;
                    sram_col_d = req_col_i;
                    sram_din_d = req_wdata_i;
`ifdef SRAM_CTRL_WR_VERIFY_EN
                    err_d      = 1'b0;
`endif
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                sram_cs_d = 1'b0;
                cnt_d     = CNT_LAST;
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    sram_cs_d = 1'b1;
                    if (rw_q) begin
                        rdata_d = sram_dout_i;
                        state_d = HOLD;
                    end else begin
`ifdef SRAM_CTRL_WR_VERIFY_EN
                        // Flip direction with cs high before the readback window.
                        state_d   = TURN;
                        sram_rw_d = 1'b1;
`else
                        state_d   = HOLD;
`endif
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
`ifdef SRAM_CTRL_WR_VERIFY_EN
            TURN: begin
                state_d   = VERIFY;
                sram_cs_d = 1'b0;
                cnt_d     = CNT_LAST;
            end
            VERIFY: begin
                // cs-low readback window, then one cs-high cycle in which the
                // sampled word is compared with the data that was written.
                if (sram_cs_q) begin
                    err_d   = (vdata_q != sram_din_q);
                    state_d = HOLD;
                end else if (cnt_q == 4'd0) begin
                    vdata_d   = sram_dout_i;
                    sram_cs_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
`endif
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and pin registers; reset parks the SRAM deselected in read direction.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            rw_q       <= 1'b1;
            sram_cs_q  <= 1'b1;
            sram_rw_q  <= 1'b1;
            sram_row_q <= 6'd0;
            sram_col_q <= 6'd0;
            sram_din_q <= 8'd0;
            rdata_q    <= 8'd0;
`ifdef SRAM_CTRL_WR_VERIFY_EN
            err_q      <= 1'b0;
            vdata_q    <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rw_q       <= rw_d;
            sram_cs_q  <= sram_cs_d;
            sram_rw_q  <= sram_rw_d;
            sram_row_q <= sram_row_d;
            sram_col_q <= sram_col_d;
            sram_din_q <= sram_din_d;
            rdata_q    <= rdata_d;
`ifdef SRAM_CTRL_WR_VERIFY_EN
            err_q      <= err_d;
            vdata_q    <= vdata_d;
`endif
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign rsp_valid_o = (state_q == HOLD);
    assign rsp_rdata_o = rdata_q;
`ifdef SRAM_CTRL_WR_VERIFY_EN
    assign wr_err_o    = (state_q == HOLD) & err_q;
`else
    assign wr_err_o    = 1'b0;
`endif
    assign sram_cs_o   = sram_cs_q;
    assign sram_rw_o   = sram_rw_q;
    assign sram_row_o  = sram_row_q;
    assign sram_col_o  = sram_col_q;
    assign sram_din_o  = sram_din_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed, table-driven bench for sram_ctrl (WAIT_CYCLES=2)
// with a behavioural 64x64x8 SRAM that can force read bit 0 high.
`define CHK(n, g, e) check(n, 32'(g), 32'(e))

module tb_sram_ctrl;

    localparam int W = 2;
`ifdef SRAM_CTRL_WR_VERIFY_EN
    localparam bit VFY = 1'b1;
`else
    localparam bit VFY = 1'b0;
`endif
    localparam int RD_LAT = W + 1;
    localparam int WR_LAT = VFY ? 2 * W + 3 : W + 1;
    localparam int WR_LOW = VFY ? 2 * W : W;

    typedef struct {
        logic       rw;
        logic [5:0] row;
        logic [5:0] col;
        logic [7:0] wdata;
        logic       stuck;
        logic [7:0] exp_rdata;
        int         exp_lat;
        logic       exp_err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_rw = 1'b1;
    logic [5:0] req_row = 6'd0;
    logic [5:0] req_col = 6'd0;
    logic [7:0] req_wdata = 8'd0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       wr_err;
    logic       busy;
    logic       sram_cs;
    logic       sram_rw;
    logic [5:0] sram_row;
    logic [5:0] sram_col;
    logic [7:0] sram_din;
    logic [7:0] sram_dout;

    logic [7:0] mem [64][64];
    logic       stuck_en = 1'b0;

    int checks = 0;
    int errors = 0;

    sram_ctrl #(.WAIT_CYCLES(W)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_rw_i    (req_rw),
        .req_row_i   (req_row),
        .req_col_i   (req_col),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .wr_err_o    (wr_err),
        .busy_o      (busy),
        .sram_cs_o   (sram_cs),
        .sram_rw_o   (sram_rw),
        .sram_row_o  (sram_row),
        .sram_col_o  (sram_col),
        .sram_din_o  (sram_din),
        .sram_dout_i (sram_dout)
    );

    always #5 clk = ~clk;

    // SRAM model: write while selected in write direction; read is combinational.
    always @(posedge clk) begin
        if (!sram_cs && !sram_rw) mem[sram_row][sram_col] <= sram_din;
    end
    assign sram_dout = mem[sram_row][sram_col] | {7'd0, stuck_en};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // One full transaction from IDLE back to IDLE, with per-cycle pin monitoring
    // and request inputs scrambled while the controller is busy.
    task automatic run_vec(input vec_t v, input string tag);
        int k, lows, rw0, bad, errhi;
        bit done;
        `CHK({tag, "_ready"}, req_ready, 1'b1);
        req_rw    = v.rw;
        req_row   = v.row;
        req_col   = v.col;
        req_wdata = v.wdata;
        stuck_en  = v.stuck;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        `CHK({tag, "_setup"}, {sram_cs, sram_rw, sram_row, sram_col, sram_din},
             {1'b1, v.rw, v.row, v.col, v.wdata});
        k = 0; lows = 0; rw0 = 0; bad = 0; errhi = 0; done = 1'b0;
        while (!done) begin
            if (rsp_valid || k >= 25) begin
                done = 1'b1;
            end else begin
                if (!sram_cs) begin
                    lows++;
                    if (!sram_rw) rw0++;
                    if (sram_row !== v.row || sram_col !== v.col || sram_din !== v.wdata) bad++;
                end
                if (v.rw && !sram_rw) bad++;
                if (wr_err) errhi++;
                req_valid = 1'($urandom_range(0, 1));
                req_rw    = 1'($urandom_range(0, 1));
                req_row   = 6'($urandom);
                req_col   = 6'($urandom);
                req_wdata = 8'($urandom);
                @(negedge clk);
                k++;
            end
        end
        req_valid = 1'b0;
        `CHK({tag, "_rsp_valid"}, rsp_valid, 1'b1);
        `CHK({tag, "_latency"}, k, v.exp_lat);
        `CHK({tag, "_rdata"}, rsp_rdata, v.exp_rdata);
        `CHK({tag, "_wr_err"}, wr_err, v.exp_err);
        `CHK({tag, "_cs_low_cycles"}, lows, v.rw ? W : WR_LOW);
        `CHK({tag, "_write_cycles"}, rw0, v.rw ? 0 : W);
        `CHK({tag, "_pins_stable"}, bad, 0);
        `CHK({tag, "_err_early"}, errhi, 0);
        @(negedge clk);
        `CHK({tag, "_pulse_end"}, {rsp_valid, wr_err, busy, req_ready}, 4'b0001);
        stuck_en = 1'b0;
    endtask

    vec_t vecs[11];
    vec_t t;

    initial begin
        int k, m, seen, hits;
        vecs[0]  = '{1'b0, 6'd1,  6'd2,  8'h80, 1'b0, 8'h00, WR_LAT, 1'b0};
        vecs[1]  = '{1'b1, 6'd1,  6'd2,  8'h3C, 1'b0, 8'h80, RD_LAT, 1'b0};
        vecs[2]  = '{1'b0, 6'd3,  6'd4,  8'h5A, 1'b0, 8'h80, WR_LAT, 1'b0};
        vecs[3]  = '{1'b1, 6'd3,  6'd4,  8'hC3, 1'b0, 8'h5A, RD_LAT, 1'b0};
        vecs[4]  = '{1'b0, 6'd63, 6'd63, 8'hFF, 1'b0, 8'h5A, WR_LAT, 1'b0};
        vecs[5]  = '{1'b1, 6'd63, 6'd63, 8'h00, 1'b0, 8'hFF, RD_LAT, 1'b0};
        vecs[6]  = '{1'b0, 6'd0,  6'd0,  8'h00, 1'b0, 8'hFF, WR_LAT, 1'b0};
        vecs[7]  = '{1'b1, 6'd0,  6'd0,  8'hA5, 1'b0, 8'h00, RD_LAT, 1'b0};
        vecs[8]  = '{1'b0, 6'd5,  6'd5,  8'h80, 1'b1, 8'h00, WR_LAT, VFY};
        vecs[9]  = '{1'b1, 6'd5,  6'd5,  8'h11, 1'b1, 8'h81, RD_LAT, 1'b0};
        vecs[10] = '{1'b1, 6'd63, 6'd63, 8'h22, 1'b0, 8'hFF, RD_LAT, 1'b0};
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 64; c++) mem[r][c] = 8'h00;

        // Reset values, observed while reset is asserted.
        #1 rst_n = 1'b0;
        #2;
        `CHK("rst_sram_pins", {sram_cs, sram_rw, sram_row, sram_col, sram_din}, {1'b1, 1'b1, 20'd0});
        `CHK("rst_rsp", {rsp_valid, rsp_rdata, wr_err}, 10'd0);
        `CHK("rst_status", {busy, req_ready}, 2'b01);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Back-to-back: req_valid held high, read request presented while the write is busy.
        `CHK("b2b_ready", req_ready, 1'b1);
        req_rw = 1'b0; req_row = 6'd2; req_col = 6'd1; req_wdata = 8'h40; req_valid = 1'b1;
        @(negedge clk);
        req_rw = 1'b1; req_row = 6'd1; req_col = 6'd2; req_wdata = 8'hEE;
        k = 0; seen = -1;
        while (!req_ready && k < 30) begin
            if (rsp_valid && seen < 0) seen = k;
            @(negedge clk);
            k++;
        end
        `CHK("b2b_write_latency", seen, WR_LAT);
        `CHK("b2b_second_handshake_edge", k + 1, WR_LAT + 2);
        @(negedge clk);
        req_valid = 1'b0;
        m = 0;
        while (!rsp_valid && m < 30) begin
            @(negedge clk);
            m++;
        end
        `CHK("b2b_read_latency", m, RD_LAT);
        `CHK("b2b_read_rdata", rsp_rdata, 8'h80);
        @(negedge clk);
        t = '{1'b1, 6'd2, 6'd1, 8'h00, 1'b0, 8'h40, RD_LAT, 1'b0};
        run_vec(t, "b2b_readback");

        // Reset in the middle of an access.
        req_rw = 1'b0; req_row = 6'd7; req_col = 6'd7; req_wdata = 8'h11; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (sram_cs && k < 10) begin
            @(negedge clk);
            k++;
        end
        `CHK("rstmid_in_access", sram_cs, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        `CHK("rstmid_cs_high", sram_cs, 1'b1);
        `CHK("rstmid_outputs", {rsp_valid, busy, req_ready, sram_rw, sram_row, sram_col, sram_din},
             {4'b0011, 20'd0});
        req_rw = 1'b1; req_row = 6'd9; req_col = 6'd9; req_valid = 1'b1;
        @(posedge clk);
        #1;
        `CHK("rstmid_no_handshake", {busy, sram_cs, sram_row}, {1'b0, 1'b1, 6'd0});
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 1'b0;
        hits = 0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid || busy) hits++;
            @(negedge clk);
        end
        `CHK("rstmid_no_rsp", hits, 0);
        `CHK("rstmid_ready", req_ready, 1'b1);
        `CHK("rstmid_rdata_cleared", rsp_rdata, 8'h00);
        t = '{1'b1, 6'd2, 6'd1, 8'h00, 1'b0, 8'h40, RD_LAT, 1'b0};
        run_vec(t, "post_reset_read");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
